// File: rtl/softmax_norm_if.sv
// Stream interface for softmax_norm: row input handshake, global enable,
// and the normalized probability output stream.
interface softmax_norm_if #(
   parameter int D_W = 32
) ();
   logic                  in_valid;
   logic                  enable;
   logic signed [D_W-1:0] qin;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_last;
   logic signed [D_W-1:0] qout;

   modport slave (
      input  in_valid, enable, qin,
      output in_ready, out_valid, out_last, qout
   );

   modport master (
      output in_valid, enable, qin,
      input  in_ready, out_valid, out_last, qout
   );
endinterface

// File: rtl/softmax_norm.sv
// softmax_norm: collects one row of non-negative exp values, sums it,
// computes factor = floor(2^DIV_BITS / sum) with a restoring divider
// (one quotient bit per enabled cycle), then replays the row as
// saturated OUT_BITS-wide probabilities.
// Optional build macro SOFTMAX_ROUND_EN: round half-up before the final
// shift instead of truncating.
module softmax_norm #(
   parameter int D_W      = 32,
   parameter int N        = 64,
   parameter int DIV_BITS = 31,
   parameter int OUT_BITS = 8
) (
   input logic          clk,
   input logic          rst,
   softmax_norm_if.slave bus
);
   localparam int PTR_W  = $clog2(N);
   localparam int SUM_W  = D_W + PTR_W;
   localparam int FAC_W  = DIV_BITS + 1;
   localparam int PROD_W = D_W + FAC_W;
   localparam int SHIFT  = DIV_BITS - OUT_BITS;
   localparam int CNT_W  = $clog2(DIV_BITS + 1);
`ifdef SOFTMAX_ROUND_EN
   localparam logic [PROD_W-1:0] RND = PROD_W'(1) << (SHIFT - 1);
`else
   localparam logic [PROD_W-1:0] RND = '0;
`endif

   typedef enum logic [1:0] {S_ACC, S_DIV, S_OUT} state_t;

   state_t              state_q;
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [SUM_W-1:0]    sum_q;
   logic [SUM_W-1:0]    rem_q;
   logic [FAC_W-1:0]    quo_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [FAC_W-1:0]    factor_q;
   logic                out_valid_q;
   logic                out_last_q;
   logic [D_W-1:0]      qout_q;
   logic [D_W-1:0]      mem_q [N];

   logic [D_W-1:0]      qin_clamp_d;
   logic                accept_d;
   logic [SUM_W:0]      rem_shift_d;
   logic                q_bit_d;
   logic [SUM_W-1:0]    rem_d;
   logic [FAC_W-1:0]    quo_d;
   logic [PROD_W-1:0]   prod_d;
   logic [PROD_W-1:0]   prod_shr_d;
   logic [OUT_BITS-1:0] prob_d;

   // Input clamp, divider step and output scaling datapath.
   always_comb begin
      qin_clamp_d = bus.qin[D_W-1] ? '0 : bus.qin;
      accept_d    = bus.enable && bus.in_valid && (state_q == S_ACC);
      // Dividend 2^DIV_BITS has only its top bit set; it enters on the first step.
      rem_shift_d = {rem_q, (cnt_q == CNT_W'(DIV_BITS))};
      q_bit_d     = (rem_shift_d >= {1'b0, sum_q});
      rem_d       = q_bit_d ? SUM_W'(rem_shift_d - {1'b0, sum_q}) : rem_shift_d[SUM_W-1:0];
      quo_d       = {quo_q[FAC_W-2:0], q_bit_d};
      prod_d      = PROD_W'(mem_q[rd_ptr_q]) * PROD_W'(factor_q);
      prod_shr_d  = (prod_d + RND) >> SHIFT;
      prob_d      = (|prod_shr_d[PROD_W-1:OUT_BITS]) ? '1 : prod_shr_d[OUT_BITS-1:0];
   end

   assign bus.in_ready  = (state_q == S_ACC) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.qout      = qout_q;

   // Row buffer write on each accepted element.
   always_ff @(posedge clk) begin
      if (!rst && accept_d)
         mem_q[wr_ptr_q] <= qin_clamp_d;
   end

   // Control FSM: accumulate row, divide, replay normalized row.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ACC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         sum_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         factor_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         qout_q      <= '0;
      end else if (bus.enable) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         case (state_q)
            S_ACC: begin
               if (bus.in_valid) begin
                  sum_q    <= sum_q + SUM_W'(qin_clamp_d);
                  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                  if (wr_ptr_q == PTR_W'(N - 1)) begin
                     state_q <= S_DIV;
                     rem_q   <= '0;
                     quo_q   <= '0;
                     cnt_q   <= CNT_W'(DIV_BITS);
                  end
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  // A zero sum yields all-ones from the divider; force it to zero.
                  factor_q <= (sum_q == '0) ? '0 : quo_d;
                  state_q  <= S_OUT;
               end
            end
            S_OUT: begin
               qout_q      <= {{(D_W - OUT_BITS){1'b0}}, prob_d};
               out_valid_q <= 1'b1;
               out_last_q  <= (rd_ptr_q == PTR_W'(N - 1));
               rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
               if (rd_ptr_q == PTR_W'(N - 1)) begin
                  state_q <= S_ACC;
                  sum_q   <= '0;
               end
            end
            default: state_q <= S_ACC;
         endcase
      end
   end
endmodule

// File: tb/tb_softmax_norm.sv
// Directed testbench for softmax_norm with N=4, DIV_BITS=31, OUT_BITS=8.
module tb_softmax_norm;
`ifdef SOFTMAX_ROUND_EN
   localparam logic [31:0] EXP_U = 32'd64;
   localparam logic [31:0] EXP_H = 32'd128;
`else
   localparam logic [31:0] EXP_U = 32'd63;
   localparam logic [31:0] EXP_H = 32'd127;
`endif
   localparam int LAT = 33;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   softmax_norm_if #(.D_W(32)) bus ();

   softmax_norm #(.D_W(32), .N(4), .DIV_BITS(31), .OUT_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          vin [4];
   logic [31:0] got [4];
   logic        got_last [4];
   int          n_got;
   int          lat;
   bit          tmo;
   int          hold_viol;

   task automatic set_vin(input int a, input int b, input int c, input int d);
      vin[0] = a; vin[1] = b; vin[2] = c; vin[3] = d;
   endtask

   // Feeds vin as one row, then captures the output row. With toggle set,
   // enable alternates every cycle and in_valid pulses while busy.
   task automatic run_row(input bit toggle);
      int   idx;
      int   guard;
      int   cyc;
      bit   acc;
      bit   en_edge;
      logic s_v, s_l, s_r;
      logic [31:0] s_q;
      idx = 0; guard = 0; cyc = 0;
      n_got = 0; lat = -1; tmo = 0; hold_viol = 0;
      while (idx < 4 && guard < 100) begin
         bus.enable   = toggle ? ~bus.enable : 1'b1;
         bus.in_valid = 1'b1;
         bus.qin      = vin[idx];
         acc     = bus.in_ready && bus.enable;
         en_edge = bus.enable;
         s_v = bus.out_valid; s_l = bus.out_last; s_r = bus.in_ready; s_q = bus.qout;
         @(posedge clk); #1;
         guard++;
         if (acc) idx++;
         if (!en_edge && (bus.out_valid !== s_v || bus.out_last !== s_l ||
                          bus.in_ready !== s_r || bus.qout !== s_q))
            hold_viol++;
      end
      bus.in_valid = 1'b0;
      if (idx < 4) tmo = 1'b1;
      guard = 0;
      while (!tmo && n_got < 4 && guard < 300) begin
         bus.enable   = toggle ? ~bus.enable : 1'b1;
         bus.in_valid = toggle ? ~bus.in_valid : 1'b0;
         bus.qin      = 32'sd999;
         en_edge = bus.enable;
         s_v = bus.out_valid; s_l = bus.out_last; s_r = bus.in_ready; s_q = bus.qout;
         @(posedge clk); #1;
         guard++;
         if (en_edge) begin
            cyc++;
            if (bus.out_valid === 1'b1) begin
               if (n_got == 0) lat = cyc;
               got[n_got]      = bus.qout;
               got_last[n_got] = bus.out_last;
               n_got++;
            end
         end else if (bus.out_valid !== s_v || bus.out_last !== s_l ||
                      bus.in_ready !== s_r || bus.qout !== s_q) begin
            hold_viol++;
         end
      end
      if (n_got < 4) tmo = 1'b1;
      bus.in_valid = 1'b0;
      bus.enable   = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; bus.enable = 1'b1; bus.in_valid = 1'b0; bus.qin = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.qout !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b vld=%b last=%b q=%0d expected 0/0/0/0",
                  bus.in_ready, bus.out_valid, bus.out_last, bus.qout);
      end
      rst = 1'b0; #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_uniform;
      set_vin(100, 100, 100, 100);
      run_row(1'b0);
      n_checks++;
      if (tmo) begin n_fail++; $display("FAIL uniform_timeout: got %0d outputs expected 4", n_got); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== EXP_U || got_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL uniform_q%0d: got %0d last=%b expected %0d last=%b", i, got[i], got_last[i], EXP_U, i == 3);
         end
      end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL uniform_latency: got %0d expected %0d", lat, LAT); end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL uniform_after_row: vld=%b rdy=%b expected 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_single_hot;
      logic [31:0] exp_q [4];
      exp_q[0] = 32'd255; exp_q[1] = 32'd0; exp_q[2] = 32'd0; exp_q[3] = 32'd0;
      set_vin(1000, 0, 0, 0);
      run_row(1'b0);
      n_checks++;
      if (tmo) begin n_fail++; $display("FAIL hot_timeout: got %0d outputs expected 4", n_got); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== exp_q[i] || got_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL hot_q%0d: got %0d last=%b expected %0d last=%b", i, got[i], got_last[i], exp_q[i], i == 3);
         end
      end
   endtask

   task automatic test_zero_sum;
      set_vin(0, 0, 0, 0);
      run_row(1'b0);
      n_checks++;
      if (tmo) begin n_fail++; $display("FAIL zero_timeout: got %0d outputs expected 4", n_got); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_q%0d: got %0d expected 0", i, got[i]);
         end
      end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
   endtask

   task automatic test_clamp;
      logic [31:0] exp_q [4];
      exp_q[0] = 32'd0; exp_q[1] = EXP_H; exp_q[2] = 32'd0; exp_q[3] = EXP_H;
      set_vin(-5, 200, -1, 200);
      run_row(1'b0);
      n_checks++;
      if (tmo) begin n_fail++; $display("FAIL clamp_timeout: got %0d outputs expected 4", n_got); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL clamp_q%0d: got %0d expected %0d", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_enable_toggle;
      set_vin(100, 100, 100, 100);
      run_row(1'b1);
      n_checks++;
      if (tmo) begin n_fail++; $display("FAIL toggle_timeout: got %0d outputs expected 4", n_got); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== EXP_U || got_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL toggle_q%0d: got %0d last=%b expected %0d last=%b", i, got[i], got_last[i], EXP_U, i == 3);
         end
      end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL toggle_latency: got %0d enabled cycles expected %0d", lat, LAT); end
      n_checks++;
      if (hold_viol != 0) begin n_fail++; $display("FAIL toggle_hold: got %0d changes in disabled cycles expected 0", hold_viol); end
   endtask

   task automatic test_reset_abort;
      bus.enable = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.in_valid = 1'b1; bus.qin = 32'sd100;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.qout !== 32'd0) begin
         n_fail++;
         $display("FAIL abort_reset_state: rdy=%b vld=%b last=%b q=%0d expected 0/0/0/0",
                  bus.in_ready, bus.out_valid, bus.out_last, bus.qout);
      end
      @(posedge clk); #1;
      rst = 1'b0; bus.in_valid = 1'b0; #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", bus.in_ready); end
      set_vin(100, 100, 100, 100);
      run_row(1'b0);
      n_checks++;
      if (tmo) begin n_fail++; $display("FAIL abort_timeout: got %0d outputs expected 4", n_got); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got[i] !== EXP_U || got_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL abort_q%0d: got %0d last=%b expected %0d last=%b", i, got[i], got_last[i], EXP_U, i == 3);
         end
      end
      n_checks++;
      if (lat != LAT) begin n_fail++; $display("FAIL abort_latency: got %0d expected %0d", lat, LAT); end
   endtask

   initial begin
      bus.enable = 1'b1; bus.in_valid = 1'b0; bus.qin = '0;
      test_reset();
      test_uniform();
      test_single_hot();
      test_zero_sum();
      test_clamp();
      test_enable_toggle();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
